// File: rtl/bcd_counter_0000_9999.sv
// Four-digit BCD counter (0000..9999) stepped by an internal prescaler tick.
// Supports up/down counting, synchronous clear, validated parallel load and status pulses.
module bcd_counter_0000_9999 #(
  parameter int TICK_DIV = 50000000,
  parameter int PRE_W    = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        up_dn,
  input  logic        clr,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [3:0]  d0,
  output logic [3:0]  d1,
  output logic [3:0]  d2,
  output logic [3:0]  d3,
  output logic        tick,
  output logic        wrap,
  output logic        load_err
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  // Returns {carry/borrow out, next digit}; values above 9 are treated as 9 on the way up.
  function automatic logic [4:0] bcd_digit_step(input logic [3:0] digit,
                                                input logic       dir_up,
                                                input logic       cin);
    logic [4:0] res;
    res = {1'b0, digit};
    if (!cin) begin
      res = {1'b0, digit};
    end else if (dir_up) begin
      if (digit >= 4'd9) res = {1'b1, 4'd0};
      else               res = {1'b0, digit + 4'd1};
    end else begin
      if (digit == 4'd0)     res = {1'b1, 4'd9};
      else if (digit > 4'd9) res = {1'b0, 4'd9};
      else                   res = {1'b0, digit - 4'd1};
    end
    return res;
  endfunction

  function automatic logic nibble_ok(input logic [3:0] n);
    return (n <= 4'd9);
  endfunction

  logic [PRE_W-1:0] r_pre;
  logic [3:0]       r_d0, r_d1, r_d2, r_d3;
  logic             r_tick, r_wrap, r_load_err;

  logic [4:0] w_s0, w_s1, w_s2, w_s3;
  logic       w_step_due;
  logic       w_load_ok;

  // Full carry/borrow ripple settles within one cycle so all digits update together.
  assign w_s0 = bcd_digit_step(r_d0, up_dn, 1'b1);
  assign w_s1 = bcd_digit_step(r_d1, up_dn, w_s0[4]);
  assign w_s2 = bcd_digit_step(r_d2, up_dn, w_s1[4]);
  assign w_s3 = bcd_digit_step(r_d3, up_dn, w_s2[4]);

  assign w_step_due = en && (r_pre == PRE_LAST);
  assign w_load_ok  = nibble_ok(load_val[3:0])  && nibble_ok(load_val[7:4]) &&
                      nibble_ok(load_val[11:8]) && nibble_ok(load_val[15:12]);

  // Prescaler, digit registers and status pulses; clr beats load beats step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre      <= '0;
      r_d0       <= 4'd0;
      r_d1       <= 4'd0;
      r_d2       <= 4'd0;
      r_d3       <= 4'd0;
      r_tick     <= 1'b0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_tick     <= 1'b0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
      if (clr) begin
        r_pre <= '0;
        r_d0  <= 4'd0;
        r_d1  <= 4'd0;
        r_d2  <= 4'd0;
        r_d3  <= 4'd0;
      end else if (load) begin
        // A rejected load also swallows any step due this cycle.
        if (w_load_ok) begin
          r_pre <= '0;
          r_d0  <= load_val[3:0];
          r_d1  <= load_val[7:4];
          r_d2  <= load_val[11:8];
          r_d3  <= load_val[15:12];
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (w_step_due) begin
        r_pre  <= '0;
        r_d0   <= w_s0[3:0];
        r_d1   <= w_s1[3:0];
        r_d2   <= w_s2[3:0];
        r_d3   <= w_s3[3:0];
        r_tick <= 1'b1;
        r_wrap <= w_s3[4];
      end else if (en) begin
        r_pre <= r_pre + {{(PRE_W-1){1'b0}}, 1'b1};
      end else begin
        r_pre <= r_pre;
      end
    end
  end

  assign d0       = r_d0;
  assign d1       = r_d1;
  assign d2       = r_d2;
  assign d3       = r_d3;
  assign tick     = r_tick;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_counter_0000_9999.sv
// Scoreboard bench: an integer modulo-10000 model predicts each clock edge,
// a negedge monitor pops expectations and compares them with the outputs.
module tb_bcd_counter_0000_9999;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst, en, up_dn, clr, load;
  logic [15:0] load_val;
  logic [3:0]  d0, d1, d2, d3;
  logic        tick, wrap, load_err;

  typedef struct {
    logic [15:0] dig;
    logic        t;
    logic        w;
    logic        le;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_val = 0;
  int   m_pre = 0;

  bcd_counter_0000_9999 #(.TICK_DIV(TD), .PRE_W(3)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .tick(tick), .wrap(wrap), .load_err(load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict the coming posedge from the current inputs, then wait for the next negedge.
  task automatic run();
    exp_t e;
    bit   ok;
    e.t = 1'b0; e.w = 1'b0; e.le = 1'b0;
    if (rst) begin
      m_val = 0; m_pre = 0;
    end else if (clr) begin
      m_val = 0; m_pre = 0;
    end else if (load) begin
      ok = 1'b1;
      for (int i = 0; i < 4; i++) if (((load_val >> (4 * i)) & 16'hF) > 9) ok = 1'b0;
      if (ok) begin
        m_val = 1000 * load_val[15:12] + 100 * load_val[11:8] + 10 * load_val[7:4] + load_val[3:0];
        m_pre = 0;
      end else begin
        e.le = 1'b1;
      end
    end else if (en) begin
      if (m_pre == TD - 1) begin
        m_pre = 0;
        e.t   = 1'b1;
        if (up_dn) begin
          e.w   = (m_val == 9999);
          m_val = (m_val + 1) % 10000;
        end else begin
          e.w   = (m_val == 0);
          m_val = (m_val + 9999) % 10000;
        end
      end else begin
        m_pre++;
      end
    end
    e.dig = to_bcd(m_val);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_val = v;
    run();
    load = 1'b0;
  endtask

  task automatic run_until_step_due();
    int guard = 0;
    while (m_pre != TD - 1 && guard < TD + 2) begin
      run();
      guard++;
    end
    check("step_align_timeout", int'(m_pre == TD - 1), 1);
  endtask

  // Monitor: every cycle the outputs are presented, compare against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("digits", {d3, d2, d1, d0}, e.dig);
      check("tick", tick, e.t);
      check("wrap", wrap, e.w);
      check("load_err", load_err, e.le);
      check("digit_range", int'(d0 <= 4'd9 && d1 <= 4'd9 && d2 <= 4'd9 && d3 <= 4'd9), 1);
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = 16'h0000;
    run();
    run();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) run();

    do_load(16'h9998);
    for (int i = 0; i < 3 * TD; i++) run();

    do_load(16'h1000);
    up_dn = 1'b0;
    for (int i = 0; i < TD; i++) run();
    do_load(16'h0000);
    for (int i = 0; i < TD; i++) run();

    up_dn = 1'b1;
    do_load(16'h12A4);
    do_load(16'h0109);
    for (int i = 0; i < TD; i++) run();

    run_until_step_due();
    clr = 1'b1; load = 1'b1; load_val = 16'h1234;
    run();
    clr = 1'b0; load = 1'b0;
    run(); run();
    en = 1'b0;
    for (int i = 0; i < 10; i++) run();
    en = 1'b1;
    for (int i = 0; i < 2 * TD; i++) run();

    do_load(16'h4567);
    #2 rst = 1'b1;
    #1;
    check("async_rst_digits", {d3, d2, d1, d0}, 16'h0000);
    check("async_rst_pulses", {tick, wrap, load_err}, 3'b000);
    run();
    rst = 1'b0;
    for (int i = 0; i < 2 * TD + 1; i++) run();

    for (int i = 0; i < 20000; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) up_dn = ~up_dn;
      clr  = ($urandom_range(0, 199) == 0);
      load = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 1) == 1)
        load_val = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                    4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      else
        load_val = 16'($urandom);
      run();
    end
    clr = 1'b0; load = 1'b0;

    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
